// File: rtl/can_xl_msg_sequencer.sv
// ---------------------------------------------------------------------------
// can_xl_msg_sequencer
//
// Frame-level sequencer for the CAN-XL controller. It sits between the
// bit-stream logic (stuffing, CRC, bit timing) and the buffer/host side.
// It follows every frame on the bus in a small FSM and knows at each moment
// whether this node is receiving or transmitting. From that it:
//   - keeps sticky error flags for the receiver and transmitter paths,
//   - drives the ACK slot and raises overload requests,
//   - produces rx/tx success pulses,
//   - asks the host to retransmit after a failed attempt, with a retry count.
//
// Optional feature macro: RETX_LIMIT_EN
//   defined   : retries are limited by retx_max (0 = unlimited). When the
//               limit is reached, retx_abort pulses instead of re_tran.
//   undefined : retx_max is ignored, retx_abort is always 0.
//
// Ports
//   clk                  system clock
//   g_rst                asynchronous reset, active-high
//   stf_err, frm_err,
//   pcrc_err, fcrc_err   receiver-side error strobes
//   bt_err, ack_err      transmitter-side error strobes
//   rcvd_eof_flg         rx end-of-frame complete strobe
//   rcvd_lst_bit_ifs     rx last IFS bit strobe
//   dt_rm_eof_tx_cmp     tx end-of-frame complete strobe
//   txed_lst_bit_ifs     tx last IFS bit strobe
//   ovld_err_tx_cmp      overload/error frame transmission complete
//   act_err_frm_tx,
//   psv_err_frm_tx       error frame in progress (either one = error frame)
//   rcvd_data_len        decoded data-field length in bits
//   rcvd_bt_cnt          bit index inside the current frame
//   de_stuff             current bit is a stuff bit
//   serial_in            sampled bus level (0 = dominant)
//   arbtr_sts            1 = arbitration won / node transmitting
//   msg_due_tx           host transmit request (held while message pending)
//   tx_buff_busy         transmit buffer holds a message
//   rx_buff_wrtn         per-buffer "full, unread" flags
//   retx_max             retry limit (0 = unlimited)
//   bt_ack_err_pre       sticky transmitter error flag
//   stf_frm_crc_err_pre  sticky receiver error flag
//   rx_success           one-cycle pulse: frame received correctly
//   tx_success           one-cycle pulse: frame transmitted correctly
//   re_tran              one-cycle pulse: retransmit the pending message
//   send_ack             drive dominant ACK in this bit
//   txmtr                node is transmitter of the current frame
//   over_ld              one-cycle overload request
//   frm_state            FSM state: 0 IDLE, 1 RX, 2 TX, 3 ERR, 4 OVLD
//   retx_cnt             retries done for the current message
//   retx_abort           one-cycle pulse: retry limit reached, message dropped
// ---------------------------------------------------------------------------
module can_xl_msg_sequencer #(
    parameter int BT_CNT_W    = 15,
    parameter int LEN_W       = 14,
    parameter int HDR_BITS    = 98,
    parameter int ACK_OFS     = 38,
    parameter int OVLD_OFS    = 48,
    parameter int OVLD_WIN    = 3,
    parameter int ARB_END_BIT = 17,
    parameter int NUM_RX_BUF  = 2,
    parameter int RETX_W      = 4
) (
    input  logic                  clk,
    input  logic                  g_rst,
    input  logic                  stf_err,
    input  logic                  frm_err,
    input  logic                  pcrc_err,
    input  logic                  fcrc_err,
    input  logic                  bt_err,
    input  logic                  ack_err,
    input  logic                  rcvd_eof_flg,
    input  logic                  rcvd_lst_bit_ifs,
    input  logic                  dt_rm_eof_tx_cmp,
    input  logic                  txed_lst_bit_ifs,
    input  logic                  ovld_err_tx_cmp,
    input  logic                  act_err_frm_tx,
    input  logic                  psv_err_frm_tx,
    input  logic [LEN_W-1:0]      rcvd_data_len,
    input  logic [BT_CNT_W-1:0]   rcvd_bt_cnt,
    input  logic                  de_stuff,
    input  logic                  serial_in,
    input  logic                  arbtr_sts,
    input  logic                  msg_due_tx,
    input  logic                  tx_buff_busy,
    input  logic [NUM_RX_BUF-1:0] rx_buff_wrtn,
    input  logic [RETX_W-1:0]     retx_max,
    output logic                  bt_ack_err_pre,
    output logic                  stf_frm_crc_err_pre,
    output logic                  rx_success,
    output logic                  tx_success,
    output logic                  re_tran,
    output logic                  send_ack,
    output logic                  txmtr,
    output logic                  over_ld,
    output logic [2:0]            frm_state,
    output logic [RETX_W-1:0]     retx_cnt,
    output logic                  retx_abort
);

    // Bit positions are compared one bit wider than the widest operand so
    // that header + length + offset can never wrap around.
    localparam int EXT_W = ((BT_CNT_W > LEN_W) ? BT_CNT_W : LEN_W) + 1;

    localparam logic [EXT_W-1:0] ACK_BASE  = EXT_W'(HDR_BITS + ACK_OFS);
    localparam logic [EXT_W-1:0] OVLD_BASE = EXT_W'(HDR_BITS + OVLD_OFS);
    localparam logic [EXT_W-1:0] OVLD_SPAN = EXT_W'(OVLD_WIN - 1);
    localparam logic [EXT_W-1:0] ARB_POS   = EXT_W'(ARB_END_BIT);
    localparam logic [EXT_W-1:0] SOF_POS   = EXT_W'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RX   = 3'd1,
        TX   = 3'd2,
        ERR  = 3'd3,
        OVLD = 3'd4
    } frm_state_t;

    frm_state_t state;
    frm_state_t state_nxt;

    // Internal registers: pending-message latch, previous host request for
    // edge detection, and "EOF reached cleanly" markers per direction.
    logic due;
    logic msg_due_d;
    logic rx_eof_ok;
    logic tx_eof_ok;

    logic              due_nxt;
    logic              rx_eof_ok_nxt;
    logic              tx_eof_ok_nxt;
    logic              txmtr_nxt;
    logic              stf_nxt;
    logic              bta_nxt;
    logic              send_ack_nxt;
    logic              over_ld_nxt;
    logic              rx_success_nxt;
    logic              tx_success_nxt;
    logic              re_tran_nxt;
    logic              retx_abort_nxt;
    logic [RETX_W-1:0] retx_cnt_nxt;

    logic              err_frm;
    logic              ifs_end;
    logic              rx_err_any;
    logic              tx_err_any;
    logic              frame_clean;
    logic              flag_clr;
    logic              clean_ifs_end;
    logic              retry_fire;
    logic              limit_hit;
    logic              msg_new;
    logic [EXT_W-1:0]  cnt_ext;
    logic [EXT_W-1:0]  ack_pos;
    logic [EXT_W-1:0]  ovld_lo;
    logic [EXT_W-1:0]  ovld_hi;

    assign frm_state = state;

    // Shared decode of the incoming strobes and the frame bit positions.
    always_comb begin
        err_frm     = act_err_frm_tx | psv_err_frm_tx;
        ifs_end     = rcvd_lst_bit_ifs | txed_lst_bit_ifs;
        rx_err_any  = stf_err | frm_err | pcrc_err | fcrc_err;
        tx_err_any  = bt_err | ack_err;
        frame_clean = ~err_frm & ~rx_err_any & ~tx_err_any
                      & ~stf_frm_crc_err_pre & ~bt_ack_err_pre;
        flag_clr    = ovld_err_tx_cmp
                      | ((rcvd_eof_flg | dt_rm_eof_tx_cmp | ifs_end) & ~err_frm);
        msg_new     = msg_due_tx & ~msg_due_d;
        cnt_ext     = EXT_W'(rcvd_bt_cnt);
        ack_pos     = EXT_W'(rcvd_data_len) + ACK_BASE;
        ovld_lo     = EXT_W'(rcvd_data_len) + OVLD_BASE;
        ovld_hi     = ovld_lo + OVLD_SPAN;
    end

    // State register: a reset anywhere in a frame returns straight to IDLE.
    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Inside an active frame an error frame beats an
    // overload request, which in turn beats the end of the IFS.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cnt_ext == SOF_POS) begin
                    state_nxt = RX;
                end
            end
            RX: begin
                if (err_frm) begin
                    state_nxt = ERR;
                end else if (over_ld) begin
                    state_nxt = OVLD;
                end else if ((cnt_ext == ARB_POS) && arbtr_sts) begin
                    state_nxt = TX;
                end else if (ifs_end) begin
                    state_nxt = IDLE;
                end
            end
            TX: begin
                if (err_frm) begin
                    state_nxt = ERR;
                end else if (over_ld) begin
                    state_nxt = OVLD;
                end else if (ifs_end) begin
                    state_nxt = IDLE;
                end
            end
            ERR, OVLD: begin
                if (ovld_err_tx_cmp) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic: computes the value every registered output takes on the
    // next edge. The success pulses are decided before the retry logic,
    // because a successful frame end must not also count as a retry point.
    always_comb begin
        // txmtr is set when arbitration is won and held through a possible
        // error/overload frame until the sequencer returns to IDLE.
        txmtr_nxt = txmtr;
        if (state_nxt == IDLE) begin
            txmtr_nxt = 1'b0;
        end else if ((state == RX) && (state_nxt == TX)) begin
            txmtr_nxt = 1'b1;
        end

        // Sticky error flags; a clear in the same cycle as a set wins.
        stf_nxt = stf_frm_crc_err_pre | (rx_err_any & ~arbtr_sts);
        bta_nxt = bt_ack_err_pre | (tx_err_any & arbtr_sts);
        if (flag_clr) begin
            stf_nxt = 1'b0;
            bta_nxt = 1'b0;
        end

        // Remember a clean EOF until the matching IFS end, per direction.
        rx_eof_ok_nxt = (state_nxt == RX)
                        & (rx_eof_ok | ((state == RX) & rcvd_eof_flg & frame_clean));
        tx_eof_ok_nxt = (state_nxt == TX)
                        & (tx_eof_ok | ((state == TX) & dt_rm_eof_tx_cmp & frame_clean));

        rx_success_nxt = (state == RX) & rcvd_lst_bit_ifs & rx_eof_ok & ~err_frm;
        tx_success_nxt = (state == TX) & txed_lst_bit_ifs & tx_eof_ok & ~err_frm;

        send_ack_nxt = ~txmtr & ~stf_frm_crc_err_pre & ~de_stuff & (cnt_ext == ack_pos);

        // Overload when every receive buffer is still full as a new frame
        // completes, or on a dominant bit inside the overload window.
        over_ld_nxt = (rx_success & (&rx_buff_wrtn))
                      | (~serial_in & (cnt_ext >= ovld_lo) & (cnt_ext <= ovld_hi));

        // A retry point is the end of an error/overload frame, or an IFS end
        // that did not complete our own transmission successfully.
        clean_ifs_end = ifs_end & ~err_frm & ~tx_success_nxt;
        retry_fire    = due & tx_buff_busy & (clean_ifs_end | ovld_err_tx_cmp);

`ifdef RETX_LIMIT_EN
        limit_hit = (retx_max != '0) && (retx_cnt == retx_max);
`else
        limit_hit = 1'b0;
`endif

        re_tran_nxt    = retry_fire & ~limit_hit;
        retx_abort_nxt = retry_fire & limit_hit;

        // The pending latch is re-armed on a new host request. When a retry
        // fires while the host still holds its request, the message remains
        // pending for the next attempt.
        due_nxt = due;
        if (retx_abort_nxt || tx_success_nxt) begin
            due_nxt = 1'b0;
        end else if (msg_new) begin
            due_nxt = 1'b1;
        end else if (re_tran_nxt) begin
            due_nxt = msg_due_tx;
        end

        // Retry counter: a retry in the same cycle as a new request wins
        // over the restart of the count.
        retx_cnt_nxt = retx_cnt;
        if (retx_abort_nxt || tx_success_nxt) begin
            retx_cnt_nxt = '0;
        end else if (re_tran_nxt) begin
            if (retx_cnt != '1) begin
                retx_cnt_nxt = retx_cnt + RETX_W'(1);
            end
        end else if (msg_new) begin
            retx_cnt_nxt = '0;
        end
    end

`ifndef RETX_LIMIT_EN
    logic unused_retx_max;
    assign unused_retx_max = ^retx_max;
`endif

    // Output and internal register bank; reset clears everything so no
    // pulse can leak out of an interrupted frame.
    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            txmtr               <= 1'b0;
            stf_frm_crc_err_pre <= 1'b0;
            bt_ack_err_pre      <= 1'b0;
            send_ack            <= 1'b0;
            over_ld             <= 1'b0;
            rx_success          <= 1'b0;
            tx_success          <= 1'b0;
            re_tran             <= 1'b0;
            retx_abort          <= 1'b0;
            retx_cnt            <= '0;
            due                 <= 1'b0;
            msg_due_d           <= 1'b0;
            rx_eof_ok           <= 1'b0;
            tx_eof_ok           <= 1'b0;
        end else begin
            txmtr               <= txmtr_nxt;
            stf_frm_crc_err_pre <= stf_nxt;
            bt_ack_err_pre      <= bta_nxt;
            send_ack            <= send_ack_nxt;
            over_ld             <= over_ld_nxt;
            rx_success          <= rx_success_nxt;
            tx_success          <= tx_success_nxt;
            re_tran             <= re_tran_nxt;
            retx_abort          <= retx_abort_nxt;
            retx_cnt            <= retx_cnt_nxt;
            due                 <= due_nxt;
            msg_due_d           <= msg_due_tx;
            rx_eof_ok           <= rx_eof_ok_nxt;
            tx_eof_ok           <= tx_eof_ok_nxt;
        end
    end

endmodule

// File: tb/tb_can_xl_msg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_can_xl_msg_sequencer
//
// Directed bench for can_xl_msg_sequencer. Each step drives the inputs for
// one clock, pushes the expected output vector onto a scoreboard queue, and
// after the edge the oldest entry is popped and compared with the outputs.
// Expected values are written by hand per step from the frame behaviour.
// ---------------------------------------------------------------------------
module tb_can_xl_msg_sequencer;

    logic        clk;
    logic        g_rst;
    logic        stf_err, frm_err, pcrc_err, fcrc_err;
    logic        bt_err, ack_err;
    logic        rcvd_eof_flg, rcvd_lst_bit_ifs;
    logic        dt_rm_eof_tx_cmp, txed_lst_bit_ifs;
    logic        ovld_err_tx_cmp;
    logic        act_err_frm_tx, psv_err_frm_tx;
    logic [13:0] rcvd_data_len;
    logic [14:0] rcvd_bt_cnt;
    logic        de_stuff, serial_in, arbtr_sts;
    logic        msg_due_tx, tx_buff_busy;
    logic [1:0]  rx_buff_wrtn;
    logic [3:0]  retx_max;
    logic        bt_ack_err_pre, stf_frm_crc_err_pre;
    logic        rx_success, tx_success, re_tran;
    logic        send_ack, txmtr, over_ld;
    logic [2:0]  frm_state;
    logic [3:0]  retx_cnt;
    logic        retx_abort;

    typedef struct packed {
        logic [2:0] st;
        logic       txm;
        logic       stf;
        logic       bta;
        logic       ack;
        logic       ovl;
        logic       rxs;
        logic       txs;
        logic       ret;
        logic       abt;
        logic [3:0] cnt;
    } exp_t;

    exp_t  e;
    exp_t  sb_exp[$];
    string sb_tag[$];
    int    checks = 0;
    int    errors = 0;

    can_xl_msg_sequencer dut (
        .clk                 (clk),
        .g_rst               (g_rst),
        .stf_err             (stf_err),
        .frm_err             (frm_err),
        .pcrc_err            (pcrc_err),
        .fcrc_err            (fcrc_err),
        .bt_err              (bt_err),
        .ack_err             (ack_err),
        .rcvd_eof_flg        (rcvd_eof_flg),
        .rcvd_lst_bit_ifs    (rcvd_lst_bit_ifs),
        .dt_rm_eof_tx_cmp    (dt_rm_eof_tx_cmp),
        .txed_lst_bit_ifs    (txed_lst_bit_ifs),
        .ovld_err_tx_cmp     (ovld_err_tx_cmp),
        .act_err_frm_tx      (act_err_frm_tx),
        .psv_err_frm_tx      (psv_err_frm_tx),
        .rcvd_data_len       (rcvd_data_len),
        .rcvd_bt_cnt         (rcvd_bt_cnt),
        .de_stuff            (de_stuff),
        .serial_in           (serial_in),
        .arbtr_sts           (arbtr_sts),
        .msg_due_tx          (msg_due_tx),
        .tx_buff_busy        (tx_buff_busy),
        .rx_buff_wrtn        (rx_buff_wrtn),
        .retx_max            (retx_max),
        .bt_ack_err_pre      (bt_ack_err_pre),
        .stf_frm_crc_err_pre (stf_frm_crc_err_pre),
        .rx_success          (rx_success),
        .tx_success          (tx_success),
        .re_tran             (re_tran),
        .send_ack            (send_ack),
        .txmtr               (txmtr),
        .over_ld             (over_ld),
        .frm_state           (frm_state),
        .retx_cnt            (retx_cnt),
        .retx_abort          (retx_abort)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pop the oldest expectation and compare it with the live outputs.
    task automatic checkOutput();
        exp_t  obs;
        exp_t  want;
        string tag;
        obs = {frm_state, txmtr, stf_frm_crc_err_pre, bt_ack_err_pre, send_ack,
               over_ld, rx_success, tx_success, re_tran, retx_abort, retx_cnt};
        checks++;
        if (sb_exp.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: observed %h required an entry", obs);
        end else begin
            want = sb_exp.pop_front();
            tag  = sb_tag.pop_front();
            assert (obs === want) else begin
                errors++;
                $error("[TB] FAIL %s: observed %h required %h", tag, obs, want);
            end
        end
    endtask

    // Zero the one-cycle strobes after each step.
    task automatic clearStrobes();
        stf_err = 0; frm_err = 0; pcrc_err = 0; fcrc_err = 0;
        bt_err = 0; ack_err = 0;
        rcvd_eof_flg = 0; rcvd_lst_bit_ifs = 0;
        dt_rm_eof_tx_cmp = 0; txed_lst_bit_ifs = 0;
        ovld_err_tx_cmp = 0; act_err_frm_tx = 0; psv_err_frm_tx = 0;
        de_stuff = 0;
    endtask

    // One clock step: queue the expectation, clock, compare, then clear the
    // strobes and the expected pulse bits for the next step.
    task automatic applyStimulus(input string tag);
        sb_exp.push_back(e);
        sb_tag.push_back(tag);
        @(posedge clk);
        #1;
        checkOutput();
        clearStrobes();
        e.ack = 0; e.ovl = 0; e.rxs = 0; e.txs = 0; e.ret = 0; e.abt = 0;
    endtask

    // Drive one failed transmit attempt (ack error, error frame, error frame
    // done); the last step leaves its outcome for the caller to check.
    task automatic failedTxFrame(input string tag);
        rcvd_bt_cnt = 15'd1; arbtr_sts = 0;
        e.st = 3'd1;
        applyStimulus({tag, "_sof"});
        rcvd_bt_cnt = 15'd17; arbtr_sts = 1;
        e.st = 3'd2; e.txm = 1;
        applyStimulus({tag, "_arb"});
        rcvd_bt_cnt = 15'd201; ack_err = 1;
        e.bta = 1;
        applyStimulus({tag, "_ackerr"});
        act_err_frm_tx = 1; rcvd_bt_cnt = 15'd0;
        e.st = 3'd3;
        applyStimulus({tag, "_errfrm"});
        arbtr_sts = 0; ovld_err_tx_cmp = 1;
        e.st = 3'd0; e.txm = 0; e.bta = 0;
    endtask

    initial begin
        g_rst = 1;
        clearStrobes();
        rcvd_data_len = 14'd64; rcvd_bt_cnt = 15'd0;
        serial_in = 1; arbtr_sts = 0;
        msg_due_tx = 0; tx_buff_busy = 0;
        rx_buff_wrtn = 2'b00; retx_max = 4'd2;
        e = '0;

        $display("[TB] reset");
        repeat (2) @(posedge clk);
        #1;
        applyStimulus("reset_state");
        g_rst = 0;
        applyStimulus("post_reset_idle");

        $display("[TB] clean receive frame, len=64");
        rcvd_bt_cnt = 15'd1;   e.st = 3'd1;
        applyStimulus("rx_sof");
        rcvd_bt_cnt = 15'd199;
        applyStimulus("rx_ack_early");
        rcvd_bt_cnt = 15'd200; de_stuff = 1;
        applyStimulus("rx_ack_on_stuff_bit");
        rcvd_bt_cnt = 15'd200; e.ack = 1;
        applyStimulus("rx_ack_slot");
        rcvd_bt_cnt = 15'd201;
        applyStimulus("rx_ack_after");
        rcvd_bt_cnt = 15'd230; rcvd_eof_flg = 1;
        applyStimulus("rx_eof");
        rcvd_lst_bit_ifs = 1;  e.st = 3'd0; e.rxs = 1;
        applyStimulus("rx_success");
        rcvd_bt_cnt = 15'd0;
        applyStimulus("rx_idle");

        $display("[TB] clean transmit frame");
        msg_due_tx = 1; tx_buff_busy = 1; rcvd_bt_cnt = 15'd1; e.st = 3'd1;
        applyStimulus("tx_sof");
        rcvd_bt_cnt = 15'd17; arbtr_sts = 1; e.st = 3'd2; e.txm = 1;
        applyStimulus("tx_arb_won");
        rcvd_bt_cnt = 15'd200;
        applyStimulus("tx_no_self_ack");
        dt_rm_eof_tx_cmp = 1;
        applyStimulus("tx_eof");
        txed_lst_bit_ifs = 1; e.st = 3'd0; e.txm = 0; e.txs = 1;
        applyStimulus("tx_success");
        msg_due_tx = 0; tx_buff_busy = 0; arbtr_sts = 0; rcvd_bt_cnt = 15'd0;
        applyStimulus("tx_idle");

        $display("[TB] receive frame with CRC error");
        rcvd_bt_cnt = 15'd1;   e.st = 3'd1;
        applyStimulus("crc_sof");
        rcvd_bt_cnt = 15'd100; fcrc_err = 1; e.stf = 1;
        applyStimulus("crc_flag_set");
        rcvd_bt_cnt = 15'd200;
        applyStimulus("crc_ack_suppressed");
        act_err_frm_tx = 1;    e.st = 3'd3;
        applyStimulus("crc_err_frame");
        ovld_err_tx_cmp = 1; rcvd_bt_cnt = 15'd0; e.st = 3'd0; e.stf = 0;
        applyStimulus("crc_err_done");

        $display("[TB] overload on full receive buffers");
        rx_buff_wrtn = 2'b11;
        rcvd_bt_cnt = 15'd1;   e.st = 3'd1;
        applyStimulus("full_sof");
        rcvd_bt_cnt = 15'd230; rcvd_eof_flg = 1;
        applyStimulus("full_eof");
        rcvd_lst_bit_ifs = 1;  e.st = 3'd0; e.rxs = 1;
        applyStimulus("full_rx_success");
        rcvd_bt_cnt = 15'd0;   e.ovl = 1;
        applyStimulus("full_over_ld");
        rx_buff_wrtn = 2'b00;
        applyStimulus("full_over_ld_end");

        $display("[TB] overload window on dominant bus");
        rcvd_bt_cnt = 15'd1;   e.st = 3'd1;
        applyStimulus("win_sof");
        rcvd_bt_cnt = 15'd209; serial_in = 0;
        applyStimulus("win_below");
        rcvd_bt_cnt = 15'd210; serial_in = 1;
        applyStimulus("win_recessive");
        rcvd_bt_cnt = 15'd210; serial_in = 0; e.ovl = 1;
        applyStimulus("win_start");
        rcvd_bt_cnt = 15'd212; e.st = 3'd4; e.ovl = 1;
        applyStimulus("win_last_bit");
        rcvd_bt_cnt = 15'd213;
        applyStimulus("win_above");
        serial_in = 1; ovld_err_tx_cmp = 1; rcvd_bt_cnt = 15'd0; e.st = 3'd0;
        applyStimulus("win_ovld_done");

        $display("[TB] retransmission with retx_max=2");
        msg_due_tx = 1; tx_buff_busy = 1;
        failedTxFrame("retry1");
        e.ret = 1; e.cnt = 4'd1;
        applyStimulus("retry1_re_tran");
        failedTxFrame("retry2");
        e.ret = 1; e.cnt = 4'd2;
        applyStimulus("retry2_re_tran");
        failedTxFrame("retry3");
`ifdef RETX_LIMIT_EN
        e.abt = 1; e.cnt = 4'd0;
`else
        e.ret = 1; e.cnt = 4'd3;
`endif
        applyStimulus("retry3_outcome");
        msg_due_tx = 0; tx_buff_busy = 0;
        applyStimulus("retry_quiet");
        msg_due_tx = 1; e.cnt = 4'd0;
        applyStimulus("retry_new_msg_clears");
        msg_due_tx = 0;
        applyStimulus("retry_new_msg_idle");

        $display("[TB] reset in the middle of a transmission");
        rcvd_bt_cnt = 15'd1;   e.st = 3'd1;
        applyStimulus("rst_sof");
        rcvd_bt_cnt = 15'd17; arbtr_sts = 1; e.st = 3'd2; e.txm = 1;
        applyStimulus("rst_arb_won");
        rcvd_bt_cnt = 15'd150; ack_err = 1; e.bta = 1;
        applyStimulus("rst_ackerr");
        #2;
        g_rst = 1;
        #1;
        e = '0;
        sb_exp.push_back(e);
        sb_tag.push_back("rst_async");
        checkOutput();
        applyStimulus("rst_held");
        g_rst = 0; arbtr_sts = 0; rcvd_bt_cnt = 15'd0;
        applyStimulus("rst_released");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
